// File: rtl/deskew_pkg.sv
// rtl/deskew_pkg.sv - shared image geometry constants and streamer state type
package deskew_pkg;

    localparam int IMG_DIM     = 28;
    localparam int PIXELS      = IMG_DIM * IMG_DIM;
    localparam int OUT_BASE    = 784;
    localparam int ADDR_STRIDE = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_INTR = 2'd2
    } stream_state_t;

endpackage

// File: rtl/pixel_skid_fifo.sv
// rtl/pixel_skid_fifo.sv - two-entry pixel buffer between BRAM read data and the stream output
module pixel_skid_fifo #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic             pop_ok;

    // A pop on an empty buffer is meaningless, so it is dropped here rather than corrupting the pointers
    assign pop_ok = pop & (count != 2'd0);
    assign head   = rd_ptr ? slot1 : slot0;
    assign occ    = count;

    // Ring storage: when full, a simultaneous push overwrites the slot being popped this same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot0  <= '0;
            slot1  <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                if (wr_ptr) begin
                    slot1 <= push_data;
                end else begin
                    slot0 <= push_data;
                end
                wr_ptr <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/deskew_streamer.sv
// rtl/deskew_streamer.sv - streams the deskewed image from BRAM to the classifier with backpressure
module deskew_streamer #(
    parameter int WIDTH       = 16,
    parameter int ADDRESS     = deskew_pkg::ADDR_STRIDE,
    parameter int BASE        = deskew_pkg::OUT_BASE,
    parameter int PIXELS      = deskew_pkg::PIXELS,
    parameter int INTR_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             ready,
    output logic             done_interrupt,
    output logic [12:0]      address,
    input  logic [WIDTH-1:0] in_data,
    output logic             en,
    output logic [3:0]       we,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast
);

    import deskew_pkg::*;

    localparam int ICW = (INTR_CYCLES > 1) ? $clog2(INTR_CYCLES) : 1;

    stream_state_t  state;
    stream_state_t  state_next;
    logic [9:0]     rd_idx;
    logic [9:0]     out_cnt;
    logic [ICW-1:0] intr_cnt;
    logic           inflight;
    logic [1:0]     occ;
    logic [WIDTH-1:0] head;
    logic           pop;
    logic           start_frame;
    logic           can_issue;
    logic [2:0]     pending;
    logic [12:0]    rd_addr;

    assign we            = 4'b0000;
    assign m_axis_tvalid = (occ != 2'd0);
    assign m_axis_tdata  = head;
    assign m_axis_tlast  = m_axis_tvalid & (out_cnt == 10'(PIXELS - 1));
    assign pop           = m_axis_tvalid & m_axis_tready;

    // Buffered plus in-flight words may never exceed the two buffer slots; a pop this cycle frees one
    assign pending   = {1'b0, occ} + {2'b00, inflight};
    assign can_issue = (rd_idx < 10'(PIXELS)) && (pending < (3'd2 + {2'b00, pop}));
    assign rd_addr   = 13'((13'(BASE) + {3'b000, rd_idx}) * 13'(ADDRESS));
    assign address   = en ? rd_addr : 13'd0;

    pixel_skid_fifo #(
        .WIDTH(WIDTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (inflight),
        .push_data(in_data),
        .pop      (pop),
        .head     (head),
        .occ      (occ)
    );

    // Frame sequencing state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle control: read issue, handshake completion, interrupt hold
    always_comb begin
        state_next     = state;
        ready          = 1'b0;
        en             = 1'b0;
        done_interrupt = 1'b0;
        start_frame    = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    start_frame = 1'b1;
                    state_next  = ST_RUN;
                end
            end
            ST_RUN: begin
                en = can_issue;
                if (pop && (out_cnt == 10'(PIXELS - 1))) begin
                    state_next = ST_INTR;
                end
            end
            ST_INTR: begin
                done_interrupt = 1'b1;
                if (intr_cnt == ICW'(INTR_CYCLES - 1)) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Read/beat/interrupt counters and the one-cycle read-latency tracker
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_idx   <= 10'd0;
            out_cnt  <= 10'd0;
            intr_cnt <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= en;
            if (start_frame) begin
                rd_idx   <= 10'd0;
                out_cnt  <= 10'd0;
                intr_cnt <= '0;
            end else begin
                if (en) begin
                    rd_idx <= rd_idx + 10'd1;
                end
                if (pop) begin
                    out_cnt <= out_cnt + 10'd1;
                end
                if (state == ST_INTR) begin
                    intr_cnt <= intr_cnt + ICW'(1);
                end
            end
        end
    end

endmodule
